// File: rtl/chu_gpi_event_if.sv
// chu_gpi_event_if -- MMIO slot bus bundle shared by the slot cores.
//
// Signals:
//   cs      : slot chip select
//   read    : read strobe (informational; reads have no side effects)
//   write   : write strobe; a register write happens when cs & write
//   addr    : 5-bit register word address
//   wr_data : 32-bit write data
//   rd_data : 32-bit read data returned by the slave
//
// Modports: master (bus controller side), slave (core side).
interface chu_gpi_event_if;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (output cs, read, write, addr, wr_data, input rd_data);
   modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_gpi_event.sv
// chu_gpi_event -- general-purpose input core with edge events and interrupt.
//
// Synchronises W asynchronous inputs, exposes their level, and captures
// enabled rising/falling edges into sticky write-1-to-clear event flags.
// irq is a registered level interrupt: irq_en & (any event pending).
//
// Register map (word address, W-bit fields, upper bits read 0):
//   0 LEVEL   RO    current (synchronised / debounced) input level
//   1 EVENT   W1C   sticky edge flags; a new edge beats a same-cycle clear
//   2 RISE_EN RW    per-bit rising-edge capture enable
//   3 FALL_EN RW    per-bit falling-edge capture enable
//   4 IRQ_EN  RW    bit 0 only
//   5..31           read 0, writes ignored
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : MMIO slot bus (chu_gpi_event_if.slave)
//   din   : W asynchronous external inputs
//   irq   : registered level interrupt
//
// Build option: define GPI_EVENT_DEBOUNCE_EN to add a per-bit debounce
// counter; LEVEL then changes only after DB_TICKS stable cycles.
module chu_gpi_event #(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_TICKS    = 20000
) (
   input  logic             clk,
   input  logic             reset,
   chu_gpi_event_if.slave   bus,
   input  logic [W-1:0]     din,
   output logic             irq
);

   logic [SYNC_STAGES-1:0][W-1:0] sync_reg;
   logic [W-1:0] s;
   logic [W-1:0] lvl_reg, lvl_next;
   logic [W-1:0] prev_reg;
   logic [W-1:0] event_reg, event_next;
   logic [W-1:0] rise_en_reg, fall_en_reg;
   logic         irq_en_reg;
   logic [W-1:0] ev_set, clr;
   logic         wr_en;
   logic         unused_bits;

   // read strobe and wr_data bits above W carry no meaning for this core
   assign unused_bits = ^{bus.read, bus.wr_data};

   assign s     = sync_reg[SYNC_STAGES-1];
   assign wr_en = bus.cs & bus.write;

   // Synchroniser chain: stage 0 samples din, last stage feeds the level logic
   always_ff @(posedge clk) begin
      if (!reset)
         sync_reg <= '0;
      else
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
   end

`ifdef GPI_EVENT_DEBOUNCE_EN
   localparam int CW = $clog2(DB_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

   // Per-bit debounce: count consecutive cycles where s differs from lvl;
   // adopt s only once it has disagreed for DB_TICKS cycles in a row.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_db
         logic [CW-1:0] cnt_reg;
         logic          differ;
         logic          expire;

         assign differ       = s[gi] ^ lvl_reg[gi];
         assign expire       = differ && (cnt_reg == CNT_LAST);
         assign lvl_next[gi] = expire ? s[gi] : lvl_reg[gi];

         always_ff @(posedge clk) begin
            if (!reset)
               cnt_reg <= '0;
            else if (!differ || expire)
               cnt_reg <= '0;
            else
               cnt_reg <= cnt_reg + 1'b1;
         end
      end
   endgenerate
`else
   assign lvl_next = s;
`endif

   // Edge detection on the level register; prev trails lvl by one cycle
   assign ev_set = (lvl_reg & ~prev_reg & rise_en_reg) |
                   (~lvl_reg & prev_reg & fall_en_reg);
   assign clr    = (wr_en && bus.addr == 5'd1) ? bus.wr_data[W-1:0] : '0;

   // Set has priority over clear on the same bit
   assign event_next = ev_set | (event_reg & ~clr);

   always_ff @(posedge clk) begin
      if (!reset) begin
         lvl_reg     <= '0;
         prev_reg    <= '0;
         event_reg   <= '0;
         rise_en_reg <= '0;
         fall_en_reg <= '0;
         irq_en_reg  <= 1'b0;
         irq         <= 1'b0;
      end else begin
         lvl_reg   <= lvl_next;
         prev_reg  <= lvl_reg;
         event_reg <= event_next;
         // uses event_next so irq rises together with the visible flag
         irq       <= irq_en_reg & (|event_next);
         if (wr_en) begin
            case (bus.addr)
               5'd2:    rise_en_reg <= bus.wr_data[W-1:0];
               5'd3:    fall_en_reg <= bus.wr_data[W-1:0];
               5'd4:    irq_en_reg  <= bus.wr_data[0];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      bus.rd_data = '0;
      case (bus.addr)
         5'd0:    bus.rd_data = 32'(lvl_reg);
         5'd1:    bus.rd_data = 32'(event_reg);
         5'd2:    bus.rd_data = 32'(rise_en_reg);
         5'd3:    bus.rd_data = 32'(fall_en_reg);
         5'd4:    bus.rd_data = {31'b0, irq_en_reg};
         default: bus.rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_chu_gpi_event.sv
// tb_chu_gpi_event -- self-checking bench for chu_gpi_event (W=8, 2 sync stages).
// The reference model describes LEVEL as "the din value applied SYNC_STAGES
// edges before, or 0 if reset was more recent", and events as "a flag sets the
// cycle after LEVEL shows an enabled transition".
module tb_chu_gpi_event;
   localparam int W  = 8;
   localparam int SS = 2;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] din = '0;
   logic         irq;

   chu_gpi_event_if bus();

   chu_gpi_event #(.W(W), .SYNC_STAGES(SS), .DB_TICKS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .din   (din),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [W-1:0] hist[$];
   logic [W-1:0] m_lvl = '0, m_prev = '0, m_ev = '0, m_rise = '0, m_fall = '0;
   logic         m_ien = 1'b0, m_irq = 1'b0;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd0:    return 32'(m_lvl);
         5'd1:    return 32'(m_ev);
         5'd2:    return 32'(m_rise);
         5'd3:    return 32'(m_fall);
         5'd4:    return {31'b0, m_ien};
         default: return 32'd0;
      endcase
   endfunction

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic tick();
      logic [W-1:0] wd, set, clr, ev_n;
      wd = bus.wr_data[W-1:0];
      if (!reset) begin
         hist.delete();
         m_lvl = '0; m_prev = '0; m_ev = '0; m_rise = '0; m_fall = '0;
         m_ien = 1'b0; m_irq = 1'b0;
      end else begin
         set  = (m_rise & m_lvl & ~m_prev) | (m_fall & ~m_lvl & m_prev);
         clr  = (bus.cs && bus.write && bus.addr == 5'd1) ? wd : '0;
         ev_n = set | (m_ev & ~clr);
         m_irq = m_ien & (|ev_n);
         m_ev  = ev_n;
         if (bus.cs && bus.write) begin
            if (bus.addr == 5'd2) m_rise = wd;
            if (bus.addr == 5'd3) m_fall = wd;
            if (bus.addr == 5'd4) m_ien  = bus.wr_data[0];
         end
         hist.push_front(din);
         if (hist.size() > 8) void'(hist.pop_back());
         m_prev = m_lvl;
         m_lvl  = (hist.size() >= SS + 1) ? hist[SS] : '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
      $display("[TB] write addr=%0d data=%08h", a, d);
      tick();
      bus.cs = 1'b0; bus.write = 1'b0; bus.wr_data = '0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
      #1;
      d = bus.rd_data;
      bus.cs = 1'b0; bus.read = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      ticks(2);
      for (int a = 0; a < 8; a++) begin
         rd(5'(a), d);
         tests++;
         if (d !== 32'd0) begin
            fails++; $display("FAIL reset_rd addr=%0d got=%08h exp=00000000", a, d);
         end
      end
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      logic [31:0] d;
      din = '0; ticks(4);
      din = 8'hA5;
      ticks(2);
      rd(5'd0, d);
      tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL latency_early got=%08h exp=00000000", d); end
      tick();
      rd(5'd0, d);
      tests++;
      if (d !== 32'h0000_00A5) begin fails++; $display("FAIL latency_level got=%08h exp=000000a5", d); end
      tests++;
      if (d !== m_read(5'd0)) begin fails++; $display("FAIL latency_model got=%08h exp=%08h", d, m_read(5'd0)); end
      $display("[TB] latency LEVEL=%08h", d);
   endtask

   task automatic test_rise_w1c();
      logic [31:0] d;
      din = '0; ticks(5);
      wr(5'd1, 32'hFF);
      wr(5'd2, 32'h0F);
      wr(5'd4, 32'h1);
      din = 8'hFF; ticks(5);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h0F || irq !== 1'b1) begin
         fails++; $display("FAIL rise_capture event=%08h irq=%b exp event=0000000f irq=1", d, irq);
      end
      wr(5'd1, 32'h05);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h0A || irq !== 1'b1) begin
         fails++; $display("FAIL w1c_partial event=%08h irq=%b exp event=0000000a irq=1", d, irq);
      end
      wr(5'd1, 32'h0A);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL w1c_all event=%08h irq=%b exp event=00000000 irq=0", d, irq);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      wr(5'd2, 32'h01);
      wr(5'd3, 32'h01);
      din = '0; ticks(5);
      wr(5'd1, 32'hFF);
      din = 8'h01; ticks(5);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h01) begin fails++; $display("FAIL both_rise got=%08h exp=00000001", d); end
      wr(5'd1, 32'h01);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL both_clear got=%08h exp=00000000", d); end
      // falling edge reaches the event register on the 4th edge: clear lands there
      din = 8'h00; ticks(3);
      wr(5'd1, 32'h01);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h01) begin fails++; $display("FAIL set_wins got=%08h exp=00000001", d); end
      tests++;
      if (d !== m_read(5'd1)) begin fails++; $display("FAIL set_wins_model got=%08h exp=%08h", d, m_read(5'd1)); end
   endtask

   task automatic test_mask();
      logic [31:0] d;
      wr(5'd2, 32'h0);
      wr(5'd3, 32'h0);
      din = 8'h08; ticks(5);
      wr(5'd1, 32'hFF);
      din = 8'h00; ticks(5);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL mask_fall got=%08h exp=00000000", d); end
      wr(5'd7, 32'hFFFF_FFFF);
      rd(5'd7, d);
      tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL unmapped_rd got=%08h exp=00000000", d); end
      for (int a = 1; a < 4; a++) begin
         rd(5'(a), d);
         tests++;
         if (d !== 32'h0) begin fails++; $display("FAIL unmapped_side addr=%0d got=%08h exp=00000000", a, d); end
      end
      wr(5'd4, 32'hFFFF_FFFF);
      rd(5'd4, d);
      tests++;
      if (d !== 32'h1) begin fails++; $display("FAIL irq_en_bits got=%08h exp=00000001", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      wr(5'd2, 32'h03);
      wr(5'd4, 32'h1);
      din = '0; ticks(5);
      wr(5'd1, 32'hFF);
      din = 8'h03; ticks(5);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h03 || irq !== 1'b1) begin
         fails++; $display("FAIL premid event=%08h irq=%b exp event=00000003 irq=1", d, irq);
      end
      din = 8'hFF;
      reset = 1'b0;
      tick();
      tests++;
      if (irq !== 1'b0) begin fails++; $display("FAIL mid_irq got=%b exp=0", irq); end
      for (int a = 0; a < 5; a++) begin
         rd(5'(a), d);
         tests++;
         if (d !== 32'h0) begin fails++; $display("FAIL mid_rd addr=%0d got=%08h exp=00000000", a, d); end
      end
      reset = 1'b1;
      ticks(6);
      rd(5'd1, d);
      tests++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         fails++; $display("FAIL post_release event=%08h irq=%b exp event=00000000 irq=0", d, irq);
      end
      rd(5'd0, d);
      tests++;
      if (d !== 32'hFF) begin fails++; $display("FAIL post_level got=%08h exp=000000ff", d); end
   endtask

   task automatic test_random();
      logic [31:0] exp;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) din = din ^ W'($urandom);
         if ($urandom_range(0, 79) == 0) begin
            reset = 1'b0; tick(); reset = 1'b1;
         end else if ($urandom_range(0, 2) == 0) begin
            wr(5'($urandom_range(0, 7)), $urandom);
         end else begin
            tick();
         end
         for (int a = 0; a < 6; a++) begin
            bus.addr = 5'(a);
            #1;
            exp = m_read(5'(a));
            tests++;
            if (bus.rd_data !== exp) begin
               fails++; $display("FAIL random_rd cyc=%0d addr=%0d got=%08h exp=%08h", n, a, bus.rd_data, exp);
            end
         end
         tests++;
         if (irq !== m_irq) begin fails++; $display("FAIL random_irq cyc=%0d got=%b exp=%b", n, irq, m_irq); end
      end
   endtask

`ifdef GPI_EVENT_DEBOUNCE_EN
   task automatic test_debounce();
      logic [31:0] d;
      din = '0; ticks(10);
      din = 8'h01; ticks(3);
      din = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick();
         rd(5'd0, d);
         tests++;
         if (d !== 32'h0) begin fails++; $display("FAIL db_glitch cyc=%0d got=%08h exp=00000000", i, d); end
      end
      din = 8'h01; ticks(5);
      rd(5'd0, d);
      tests++;
      if (d !== 32'h0) begin fails++; $display("FAIL db_early got=%08h exp=00000000", d); end
      tick();
      rd(5'd0, d);
      tests++;
      if (d !== 32'h1) begin fails++; $display("FAIL db_stable got=%08h exp=00000001", d); end
   endtask
`endif

   initial begin
      bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.addr = '0; bus.wr_data = '0;
      test_reset();
`ifdef GPI_EVENT_DEBOUNCE_EN
      test_debounce();
`else
      test_latency();
      test_rise_w1c();
      test_collision();
      test_mask();
      test_reset_mid();
      test_random();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
